// File: rtl/tone_sequencer_if.sv
// Request/audio bundle between the game FSM (master) and the tone sequencer (slave).
// start is a one-cycle request that is always accepted: no ready, no back-pressure.
interface tone_sequencer_if;
  logic       start;
  logic [1:0] sound;
  logic       mute;
  logic       busy;
  logic       left;
  logic       right;

  modport master (output start, output sound, output mute,
                  input  busy,  input  left,  input  right);
  modport slave  (input  start, input  sound, input  mute,
                  output busy,  output left,  output right);
endinterface

// File: rtl/tone_sequencer.sv
// Square-wave tone generator: one of three tones for a fixed duration per start pulse,
// with optional stereo routing and an output-only mute.
module tone_sequencer #(
  parameter int               DIV_W     = 20,
  parameter int               DUR_W     = 24,
  parameter logic [DIV_W-1:0] HALF_PING = DIV_W'(32768),
  parameter logic [DIV_W-1:0] HALF_PONG = DIV_W'(131072),
  parameter logic [DIV_W-1:0] HALF_GOAL = DIV_W'(262144),
  parameter logic [DUR_W-1:0] DUR_PING  = DUR_W'(4000000),
  parameter logic [DUR_W-1:0] DUR_PONG  = DUR_W'(4000000),
  parameter logic [DUR_W-1:0] DUR_GOAL  = DUR_W'(12000000),
  parameter bit               STEREO    = 1'b0
) (
  input  logic                snd_clk,
  input  logic                rst_n,
  tone_sequencer_if.slave     bus,
  output logic                dbg_play_o
);

  typedef enum logic {S_IDLE = 1'b0, S_PLAY = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [1:0]         tone_q,  tone_d;
  logic [DIV_W-1:0]   div_q,   div_d;
  logic [DUR_W-1:0]   dur_q,   dur_d;
  logic               wave_q,  wave_d;

  logic [DIV_W-1:0]   half_sel;
  logic [DIV_W-1:0]   half_eff;
  logic [DUR_W-1:0]   dur_new;
  logic               lenable;
  logic               renable;

  always_comb begin
    half_sel = DIV_W'(1);
    case (tone_q)
      2'd1:    half_sel = HALF_PING;
      2'd2:    half_sel = HALF_PONG;
      2'd3:    half_sel = HALF_GOAL;
      default: half_sel = DIV_W'(1);
    endcase
    // A zero half-period would never toggle; run it as the fastest tone instead.
    half_eff = (half_sel == '0) ? DIV_W'(1) : half_sel;
  end

  always_comb begin
    dur_new = '0;
    case (bus.sound)
      2'd1:    dur_new = DUR_PING;
      2'd2:    dur_new = DUR_PONG;
      2'd3:    dur_new = DUR_GOAL;
      default: dur_new = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    tone_d  = tone_q;
    div_d   = div_q;
    dur_d   = dur_q;
    wave_d  = wave_q;
    if (bus.start) begin
      // A new request always restarts phase and duration, even for the same tone.
      wave_d = 1'b0;
      if (bus.sound != 2'd0) begin
        tone_d  = bus.sound;
        div_d   = '0;
        dur_d   = dur_new;
        state_d = (dur_new == '0) ? S_IDLE : S_PLAY;
      end else begin
        state_d = S_IDLE;
      end
    end else if (state_q == S_PLAY) begin
      if (div_q == half_eff - DIV_W'(1)) begin
        div_d  = '0;
        wave_d = ~wave_q;
      end else begin
        div_d  = div_q + DIV_W'(1);
      end
      dur_d = dur_q - DUR_W'(1);
      if (dur_q == DUR_W'(1)) begin
        state_d = S_IDLE;
        wave_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge snd_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      tone_q  <= 2'd0;
      div_q   <= '0;
      dur_q   <= '0;
      wave_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tone_q  <= tone_d;
      div_q   <= div_d;
      dur_q   <= dur_d;
      wave_q  <= wave_d;
    end
  end

  always_comb begin
    lenable = 1'b1;
    renable = 1'b1;
    if (STEREO) begin
      lenable = (tone_q != 2'd2);
      renable = (tone_q != 2'd1);
    end
  end

  assign bus.busy   = (state_q == S_PLAY);
  assign bus.left   = wave_q & ~bus.mute & lenable;
  assign bus.right  = wave_q & ~bus.mute & renable;
  assign dbg_play_o = (state_q == S_PLAY);

endmodule

// File: tb/tb_tone_sequencer.sv
// Directed bench for tone_sequencer: a mono and a stereo instance share one stimulus stream.
module tb_tone_sequencer;

  logic snd_clk;
  logic rst_n;
  logic dbg0;
  logic dbg1;
  logic mute_r;

  int n_checks;
  int n_pass;

  tone_sequencer_if u_if0 ();
  tone_sequencer_if u_if1 ();

  tone_sequencer #(
    .HALF_PING(20'd2), .HALF_PONG(20'd3), .HALF_GOAL(20'd0),
    .DUR_PING(24'd10), .DUR_PONG(24'd12), .DUR_GOAL(24'd5),
    .STEREO(1'b0)
  ) u_dut_mono (
    .snd_clk   (snd_clk),
    .rst_n     (rst_n),
    .bus       (u_if0.slave),
    .dbg_play_o(dbg0)
  );

  tone_sequencer #(
    .HALF_PING(20'd2), .HALF_PONG(20'd3), .HALF_GOAL(20'd0),
    .DUR_PING(24'd10), .DUR_PONG(24'd12), .DUR_GOAL(24'd5),
    .STEREO(1'b1)
  ) u_dut_stereo (
    .snd_clk   (snd_clk),
    .rst_n     (rst_n),
    .bus       (u_if1.slave),
    .dbg_play_o(dbg1)
  );

  // clock / reset
  initial begin
    snd_clk = 1'b0;
    forever #5 snd_clk = ~snd_clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // driver tasks
  task automatic set_in(input logic start, input logic [1:0] sound);
    u_if0.start = start;
    u_if0.sound = sound;
    u_if1.start = start;
    u_if1.sound = sound;
  endtask

  task automatic set_mute(input logic m);
    mute_r     = m;
    u_if0.mute = m;
    u_if1.mute = m;
  endtask

  task automatic step();
    @(posedge snd_clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] sound);
    set_in(1'b1, sound);
    step();
    set_in(1'b0, 2'd0);
  endtask

  // expected outputs for both instances given the tone, busy and raw wave
  task automatic check_outs(input string tag, input logic [1:0] tone,
                            input logic exp_busy, input logic wave);
    logic lm;
    lm = wave & ~mute_r;
    check({tag, ".busy0"},  u_if0.busy,  exp_busy);
    check({tag, ".busy1"},  u_if1.busy,  exp_busy);
    check({tag, ".dbg0"},   dbg0,        exp_busy);
    check({tag, ".left0"},  u_if0.left,  lm);
    check({tag, ".right0"}, u_if0.right, lm);
    check({tag, ".left1"},  u_if1.left,  lm & (tone != 2'd2));
    check({tag, ".right1"}, u_if1.right, lm & (tone != 2'd1));
  endtask

  // pat bit i = expected wave at sample i after the start edge
  task automatic observe(input string tag, input logic [1:0] tone, input int n,
                         input logic [31:0] pat);
    for (int i = 0; i < n; i++) begin
      if (i > 0) step();
      check_outs($sformatf("%s[%0d]", tag, i), tone, 1'b1, pat[i]);
    end
  endtask

  task automatic expect_idle(input string tag);
    check_outs(tag, 2'd0, 1'b0, 1'b0);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    set_in(1'b0, 2'd0);
    set_mute(1'b0);
    #2;
    expect_idle("reset");
    step();
    rst_n = 1'b1;

    // 1: idle after reset
    for (int i = 0; i < 50; i++) begin
      step();
      expect_idle($sformatf("idle[%0d]", i));
    end

    // 2: ping, H=2, 10 cycles
    issue(2'd1);
    observe("ping", 2'd1, 10, 32'h0CC);
    step();
    expect_idle("ping_end");

    // 3: pong, H=3, 12 cycles; then goal, H=0 -> 1, 5 cycles
    issue(2'd2);
    observe("pong", 2'd2, 12, 32'hE38);
    step();
    expect_idle("pong_end");
    issue(2'd3);
    observe("goal", 2'd3, 5, 32'h00A);
    step();
    expect_idle("goal_end");

    // 4: ping restarted by pong 4 cycles later
    issue(2'd1);
    observe("rs_ping", 2'd1, 4, 32'h0CC);
    issue(2'd2);
    observe("rs_pong", 2'd2, 12, 32'hE38);
    step();
    expect_idle("rs_end");

    // 5: stop request mid-ping
    issue(2'd1);
    observe("st_ping", 2'd1, 3, 32'h0CC);
    issue(2'd0);
    expect_idle("stop0");
    step();
    expect_idle("stop1");

    // 6a: mute during goal keeps timing running
    set_mute(1'b1);
    issue(2'd3);
    observe("mute_goal", 2'd3, 5, 32'h00A);
    step();
    expect_idle("mute_end");
    set_mute(1'b0);
    step();

    // 6b: asynchronous reset mid-tone, while the wave is high
    issue(2'd3);
    observe("rst_goal", 2'd3, 2, 32'h00A);
    #1;
    rst_n = 1'b0;
    #1;
    expect_idle("async_rst");
    step();
    rst_n = 1'b1;
    step();
    expect_idle("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
